// File: rtl/cnn_pkg.sv
// cnn_pkg: geometry and pixel-format constants shared by the conv2 window buffer and the MAC calculators.
package cnn_pkg;
  localparam int FILTER_SIZE = 5;
  localparam int TAPS = FILTER_SIZE * FILTER_SIZE;
  localparam int CONV2_WIDTH = 12;
  localparam int CONV2_HEIGHT = 12;
  localparam int CONV2_DATA_BITS = 12;
endpackage

// File: rtl/raster_pos_counter.sv
// raster_pos_counter: tracks the (x,y) raster coordinate of the pixel being accepted and flags full-window positions.
module raster_pos_counter
  import cnn_pkg::*;
#(
  parameter int WIDTH = CONV2_WIDTH,
  parameter int HEIGHT = CONV2_HEIGHT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  output logic in_window
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic x_end, y_end;
  assign x_end = x == XW'(WIDTH - 1);
  assign y_end = y == YW'(HEIGHT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      x <= x_end ? '0 : x + 1'b1;
      if (x_end) y <= y_end ? '0 : y + 1'b1;
    end
  end
  // Gating on both coordinates keeps windows from straddling row wraps or frames.
  assign in_window = x >= XW'(FILTER_SIZE - 1) && y >= YW'(FILTER_SIZE - 1);
endmodule

// File: rtl/conv2_window_buf.sv
// conv2_window_buf: 5x5 sliding-window line buffer presenting all taps of the current window in parallel.
module conv2_window_buf
  import cnn_pkg::*;
#(
  parameter int WIDTH = CONV2_WIDTH,
  parameter int HEIGHT = CONV2_HEIGHT,
  parameter int DATA_BITS = CONV2_DATA_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [DATA_BITS-1:0]      max_value,
  output logic [TAPS*DATA_BITS-1:0] data_out,
  output logic                      valid_out_buf
);
  localparam int DEPTH = (FILTER_SIZE - 1) * WIDTH + FILTER_SIZE;
  if (WIDTH < FILTER_SIZE || HEIGHT < FILTER_SIZE) begin : g_bad_geometry
    $error("conv2_window_buf: WIDTH and HEIGHT must be at least %0d", FILTER_SIZE);
  end
  logic [DEPTH-1:0][DATA_BITS-1:0] sr;
  logic in_window;
  raster_pos_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_pos (
    .clk(clk),
    .rst_n(rst_n),
    .advance(valid_in),
    .in_window(in_window)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      valid_out_buf <= 1'b0;
    end else begin
      valid_out_buf <= valid_in && in_window;
      if (valid_in) sr <= {sr[DEPTH-2:0], max_value};
    end
  end
  // Entry 0 is the newest pixel, so the bottom-right tap reads entry 0 and the top-left the oldest.
  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    for (genvar c = 0; c < FILTER_SIZE; c++) begin : g_col
      assign data_out[(FILTER_SIZE*r+c)*DATA_BITS +: DATA_BITS] =
        sr[(FILTER_SIZE-1-r)*WIDTH + (FILTER_SIZE-1-c)];
    end
  end
endmodule

// File: tb/tb_conv2_window_buf.sv
// tb_conv2_window_buf: checks default and 8x6 window buffers against a coordinate-based frame model.
module tb_conv2_window_buf;
  localparam int DB = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic va = 1'b0, vb = 1'b0;
  logic [DB-1:0] da = '0, db = '0;
  logic [25*DB-1:0] dout [2];
  logic vo [2];
  int checks = 0, errors = 0;
  int strb [2];
  logic [DB-1:0] img [2][12][12];
  int n [2];
  logic expv [2];
  logic [DB-1:0] expt [2][25];

  always #5 clk = ~clk;

  conv2_window_buf dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(va), .max_value(da),
    .data_out(dout[0]), .valid_out_buf(vo[0])
  );
  conv2_window_buf #(.WIDTH(8), .HEIGHT(6), .DATA_BITS(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(vb), .max_value(db),
    .data_out(dout[1]), .valid_out_buf(vo[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DB-1:0] tap(input int k, input int i);
    return dout[k][i*DB +: DB];
  endfunction

  // Model: place each accepted pixel at its raster coordinate; a window exists once x>=4 and y>=4.
  task automatic model_step(input int k, input int w, input int h, input logic v, input logic [DB-1:0] d);
    int x, y;
    expv[k] = 1'b0;
    if (v) begin
      x = n[k] % w;
      y = (n[k] / w) % h;
      img[k][y][x] = d;
      if (x >= 4 && y >= 4) begin
        expv[k] = 1'b1;
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            expt[k][5*r+c] = img[k][y-4+r][x-4+c];
      end
      n[k]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        n[k] = 0;
        expv[k] = 1'b0;
        for (int t = 0; t < 25; t++) expt[k][t] = '0;
      end
    end else begin
      model_step(0, 12, 12, va, da);
      model_step(1, 8, 6, vb, db);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("strobe%0d", k), 32'(vo[k]), 32'(expv[k]));
      if (expv[k])
        for (int t = 0; t < 25; t++)
          check($sformatf("inst%0d_tap%0d", k, t), 32'(tap(k, t)), 32'(expt[k][t]));
      if (!rst_n) check($sformatf("inst%0d_reset_taps_zero", k), 32'(|dout[k]), 32'd0);
      if (vo[k] === 1'b1) strb[k]++;
    end
  end

  task automatic send_a(input int d);
    va = 1'b1;
    da = DB'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input int d);
    vb = 1'b1;
    db = DB'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    va = 1'b0;
    vb = 1'b0;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobe", 32'(vo[0]), 32'd0);
    check("reset_tap24", 32'(tap(0, 24)), 32'd0);
    rst_n = 1'b1;
    idle(1);
    // ramp frame and row boundary
    strb[0] = 0;
    for (int i = 0; i < 144; i++) begin
      send_a(i);
      if (i == 51) check("ramp_no_early_strobe", 32'(vo[0]), 32'd0);
      if (i == 52) begin
        check("ramp_first_strobe", 32'(vo[0]), 32'd1);
        check("ramp_first_tap0", 32'(tap(0, 0)), 32'd0);
        check("ramp_first_tap4", 32'(tap(0, 4)), 32'd4);
        check("ramp_first_tap5", 32'(tap(0, 5)), 32'd12);
        check("ramp_first_tap14", 32'(tap(0, 14)), 32'd28);
        check("ramp_first_tap20", 32'(tap(0, 20)), 32'd48);
        check("ramp_first_tap24", 32'(tap(0, 24)), 32'd52);
      end
      if (i >= 60 && i <= 63) check("row5_x_lt4_no_strobe", 32'(vo[0]), 32'd0);
      if (i == 64) begin
        check("row5_first_strobe", 32'(vo[0]), 32'd1);
        check("row5_first_tap0", 32'(tap(0, 0)), 32'd12);
        check("row5_first_tap24", 32'(tap(0, 24)), 32'd64);
      end
      if (i == 143) begin
        check("ramp_last_tap0", 32'(tap(0, 0)), 32'd91);
        check("ramp_last_tap24", 32'(tap(0, 24)), 32'd143);
      end
    end
    idle(2);
    check("ramp_strobe_count", 32'(strb[0]), 32'd64);
    // gapped input
    strb[0] = 0;
    for (int i = 0; i < 144; i++) begin
      send_a(i);
      if (i == 52) begin
        check("gap_first_tap0", 32'(tap(0, 0)), 32'd0);
        check("gap_first_tap24", 32'(tap(0, 24)), 32'd52);
      end
      idle(1);
      if (i == 52) check("gap_strobe_low", 32'(vo[0]), 32'd0);
    end
    idle(2);
    check("gap_strobe_count", 32'(strb[0]), 32'd64);
    // back-to-back frames
    strb[0] = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 144; i++) begin
        send_a(f * 200 + i);
        if (f == 1 && i == 52) begin
          check("frame2_first_strobe", 32'(vo[0]), 32'd1);
          check("frame2_first_tap0", 32'(tap(0, 0)), 32'd200);
          check("frame2_first_tap24", 32'(tap(0, 24)), 32'd252);
        end
      end
    idle(2);
    check("b2b_strobe_count", 32'(strb[0]), 32'd128);
    // mid-frame reset with valid_in held high during reset
    for (int i = 0; i < 70; i++) send_a(i);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_a(999);
      check("midrst_taps_zero", 32'(|dout[0]), 32'd0);
      check("midrst_strobe_zero", 32'(vo[0]), 32'd0);
    end
    va = 1'b0;
    rst_n = 1'b1;
    idle(1);
    strb[0] = 0;
    for (int i = 0; i < 144; i++) begin
      send_a(i);
      if (i == 51) check("post_rst_no_early", 32'(vo[0]), 32'd0);
      if (i == 52) begin
        check("post_rst_first_strobe", 32'(vo[0]), 32'd1);
        check("post_rst_tap0", 32'(tap(0, 0)), 32'd0);
        check("post_rst_tap10", 32'(tap(0, 10)), 32'd24);
        check("post_rst_tap24", 32'(tap(0, 24)), 32'd52);
      end
    end
    idle(2);
    check("post_rst_strobe_count", 32'(strb[0]), 32'd64);
    // non-default geometry 8x6
    strb[1] = 0;
    for (int i = 0; i < 48; i++) begin
      send_b(i);
      if (i == 35) check("w8_no_early", 32'(vo[1]), 32'd0);
      if (i == 36) begin
        check("w8_first_strobe", 32'(vo[1]), 32'd1);
        check("w8_first_tap0", 32'(tap(1, 0)), 32'd0);
        check("w8_first_tap24", 32'(tap(1, 24)), 32'd36);
      end
    end
    idle(2);
    check("w8_strobe_count", 32'(strb[1]), 32'd8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
